// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer and registered upstream ready.
// Optional performance counters are compiled in when IFID_PERF_CNT_EN is defined.
module if_id_skid_stage #(
  parameter int          XLEN     = 32,
  parameter int          ILEN     = 32,
  parameter int          LANES    = 1,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [XLEN-1:0]       up_pc_i,
  input  logic [LANES*ILEN-1:0] up_insn_i,
  input  logic [LANES-1:0]      up_mask_i,
  input  logic                  up_fault_i,
  output logic                  dn_valid_o,
  input  logic                  dn_ready_i,
  output logic [XLEN-1:0]       dn_pc_o,
  output logic [LANES*ILEN-1:0] dn_insn_o,
  output logic [LANES-1:0]      dn_mask_o,
  output logic                  dn_fault_o
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o,
  output logic [31:0]           perf_bubble_cnt_o
`endif
);

  localparam int PKT_W = XLEN + LANES*ILEN + LANES + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  function automatic logic [LANES*ILEN-1:0] nop_lanes();
    logic [LANES*ILEN-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      v[l*ILEN +: ILEN] = ILEN'(NOP_INST);
    end
    return v;
  endfunction

  localparam logic [PKT_W-1:0] CLR_PKT = {{XLEN{1'b0}}, nop_lanes(), {LANES{1'b0}}, 1'b0};

  logic [1:0]       state_q, state_d;
  logic             rdy_q;
  logic             vld_p1;
  logic [PKT_W-1:0] main_p1, main_d;
  logic [PKT_W-1:0] skid_p0, skid_d;
  logic [PKT_W-1:0] in_pkt;
  logic             up_fire, dn_fire;

  assign in_pkt  = {up_pc_i, up_insn_i, up_mask_i, up_fault_i};
  assign up_fire = up_valid_i & rdy_q;
  assign dn_fire = vld_p1 & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_p1;
    skid_d  = skid_p0;
    case (state_q)
      ST_EMPTY: begin
        if (up_fire) begin
          state_d = ST_FULL;
          main_d  = in_pkt;
        end
      end
      ST_FULL: begin
        if (up_fire && dn_fire) begin
          main_d = in_pkt;
        end else if (up_fire) begin
          state_d = ST_SKID;
          skid_d  = in_pkt;
        end else if (dn_fire) begin
          state_d = ST_EMPTY;
          main_d  = CLR_PKT;
        end
      end
      ST_SKID: begin
        // Skid entry is always older than anything upstream, so it drains first.
        if (dn_fire) begin
          state_d = ST_FULL;
          main_d  = skid_p0;
          skid_d  = CLR_PKT;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = CLR_PKT;
        skid_d  = CLR_PKT;
      end
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = CLR_PKT;
      skid_d  = CLR_PKT;
    end
  end

  // Stage register: state, registered ready/valid, main and skid entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      vld_p1  <= 1'b0;
      main_p1 <= CLR_PKT;
      skid_p0 <= CLR_PKT;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_SKID);
      vld_p1  <= (state_d != ST_EMPTY);
      main_p1 <= main_d;
      skid_p0 <= skid_d;
    end
  end

  assign up_ready_o = rdy_q;
  assign dn_valid_o = vld_p1;
  assign {dn_pc_o, dn_insn_o, dn_mask_o, dn_fault_o} = main_p1;

`ifdef IFID_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        started_q;
  logic        flush_discard;
  logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

  // A main entry consumed by decode in the flush cycle is not a discard.
  assign flush_discard = flush_i & (up_fire | (vld_p1 & ~dn_ready_i) | (state_q == ST_SKID));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (up_fire) started_q <= 1'b1;
      if (vld_p1 && !dn_ready_i) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_discard) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (started_q && !vld_p1) bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_flush_cnt_o  = flush_cnt_q;
  assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
